hd63701_sci_fifo: RTL

Parametrised serial communication interface for the HD63701-compatible MCU: full-duplex asynchronous UART with a programmable 16x-oversampled baud generator, optional parity, and separate RX/TX FIFOs of configurable depth. It sits on the internal peripheral bus beside the I/O port and timer blocks. It returns read data through the built-in device data selector and raises a level interrupt into the core's IRQ2 input. It supersedes the single-buffered 8-bit SCI.

---
 rtl/hd63701_sci_pkg.sv | 49 ++++
 rtl/hd63701_sync_fifo.sv | 60 ++++++
 rtl/hd63701_sci_fifo.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hd63701_sci_pkg.sv
// Shared constants, state encodings and parity helper for the HD63701 SCI with FIFOs.
package hd63701_sci_pkg;

   localparam logic [1:0] OFF_CTRL = 2'd0;
   localparam logic [1:0] OFF_STAT = 2'd1;
   localparam logic [1:0] OFF_DATA = 2'd2;
   localparam logic [1:0] OFF_DIV  = 2'd3;

   localparam int CTRL_RE   = 0;
   localparam int CTRL_TE   = 1;
   localparam int CTRL_RIE  = 2;
   localparam int CTRL_TIE  = 3;
   localparam int CTRL_PEN  = 4;
   localparam int CTRL_PODD = 5;

   localparam int STAT_RXNE    = 0;
   localparam int STAT_RXFULL  = 1;
   localparam int STAT_TXEMPTY = 2;
   localparam int STAT_TXNF    = 3;
   localparam int STAT_ORE     = 4;
   localparam int STAT_FE      = 5;
   localparam int STAT_PE      = 6;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] TICK_MID   = 4'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_PAR   = 3'd3,
      RX_STOP  = 3'd4
   } rx_state_e;

   typedef enum logic [2:0] {
      TX_IDLE  = 3'd0,
      TX_START = 3'd1,
      TX_DATA  = 3'd2,
      TX_PAR   = 3'd3,
      TX_STOP  = 3'd4
   } tx_state_e;

   // Parity bit that makes the frame even (odd when odd is set).
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/hd63701_sync_fifo.sv
// Single-clock FIFO; a push on a full FIFO is accepted only when a pop happens in the same cycle.
module hd63701_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (count_q == CW'(0));
   assign full      = (count_q == CW'(DEPTH));
   assign count     = count_q;
   assign rdata     = mem_q[rd_ptr_q];
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1'b1);
         if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1'b1);
         count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   // Storage array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/hd63701_sci_fifo.sv
// HD63701 serial interface: 16x-oversampled UART with programmable divisor, optional parity,
// and RX/TX FIFOs behind a 4-byte register window.
module hd63701_sci_fifo
   import hd63701_sci_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'h0010,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  DIV_RST    = 8'h00
) (
   input  logic        mcu_clx2,
   input  logic        mcu_rst_n,
   input  logic [15:0] mcu_ad,
   input  logic        mcu_wr,
   input  logic        mcu_rd,
   input  logic [7:0]  mcu_do,
   output logic        en_sci,
   output logic [7:0]  iod,
   input  logic        rx,
   output logic        tx,
   output logic        te,
   output logic        irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [15:0] offset_s;
   logic [1:0]  reg_sel_s;
   logic wr_ctrl_s, wr_stat_s, wr_data_s, wr_div_s, rd_data_s, te_clr_s, re_clr_s;
   logic [5:0]  ctrl_q;
   logic [7:0]  div_q, presc_q, stat_s;
   logic        tick_s;
   logic        ore_q, fe_q, pe_q, irq_q, ore_d, fe_d, pe_d, irq_d;
   logic        ore_set_s, fe_set_s, pe_set_s;
   logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall_s;
   rx_state_e   rx_state_q, rx_state_d;
   logic [3:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_par_q, rx_par_d, rx_bit_end_s, rx_push_s;
   tx_state_e   tx_state_q, tx_state_d;
   logic [3:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_q, tx_d, tx_bit_end_s, tx_pop_s;
   logic [7:0]  rxf_rdata_s, txf_rdata_s;
   logic        rxf_full_s, rxf_empty_s, txf_full_s, txf_empty_s, txempty_s;
   logic [CW-1:0] rxf_count_s, txf_count_s;

   // Window decode by subtraction so an unaligned BASE_ADDR still maps four bytes.
   assign offset_s  = mcu_ad - BASE_ADDR;
   assign en_sci    = (offset_s < 16'd4);
   assign reg_sel_s = offset_s[1:0];
   assign wr_ctrl_s = en_sci & mcu_wr & (reg_sel_s == OFF_CTRL);
   assign wr_stat_s = en_sci & mcu_wr & (reg_sel_s == OFF_STAT);
   assign wr_data_s = en_sci & mcu_wr & (reg_sel_s == OFF_DATA);
   assign wr_div_s  = en_sci & mcu_wr & (reg_sel_s == OFF_DIV);
   assign rd_data_s = en_sci & mcu_rd & (reg_sel_s == OFF_DATA);
   assign te_clr_s  = wr_ctrl_s & ctrl_q[CTRL_TE] & ~mcu_do[CTRL_TE];
   assign re_clr_s  = wr_ctrl_s & ctrl_q[CTRL_RE] & ~mcu_do[CTRL_RE];
   assign tick_s    = (presc_q == div_q);

   assign txempty_s = (txf_count_s == CW'(0)) & (tx_state_q == TX_IDLE);
   assign stat_s    = {1'b0, pe_q, fe_q, ore_q, ~txf_full_s, txempty_s,
                       (rxf_count_s == CW'(FIFO_DEPTH)), ~rxf_empty_s};

   // Register read mux.
   always_comb begin
      iod = 8'h00;
      if (en_sci) begin
         case (reg_sel_s)
            OFF_CTRL: iod = {2'b00, ctrl_q};
            OFF_STAT: iod = stat_s;
            OFF_DATA: iod = rxf_rdata_s;
            OFF_DIV:  iod = div_q;
            default:  iod = 8'h00;
         endcase
      end else begin
         iod = 8'h00;
      end
   end

   // Control/divisor registers and baud prescaler.
   always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
      if (!mcu_rst_n) begin
         ctrl_q  <= 6'd0;
         div_q   <= DIV_RST;
         presc_q <= 8'd0;
      end else begin
         if (wr_ctrl_s) ctrl_q <= mcu_do[5:0];
         if (wr_div_s)  div_q  <= mcu_do;
         presc_q <= (wr_div_s || tick_s) ? 8'd0 : presc_q + 8'd1;
      end
   end

   // Sticky error flags: a same-cycle set overrides the write-one-to-clear.
   assign ore_set_s = rx_push_s & rxf_full_s & ~rd_data_s;
   assign ore_d = (ore_q & ~(wr_stat_s & mcu_do[STAT_ORE])) | ore_set_s;
   assign fe_d  = (fe_q  & ~(wr_stat_s & mcu_do[STAT_FE]))  | fe_set_s;
   assign pe_d  = (pe_q  & ~(wr_stat_s & mcu_do[STAT_PE]))  | pe_set_s;
   assign irq_d = (ctrl_q[CTRL_RIE] & (~rxf_empty_s | ore_q | fe_q | pe_q)) |
                  (ctrl_q[CTRL_TIE] & txempty_s);

   // Status flags, irq and RX synchroniser.
   always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
      if (!mcu_rst_n) begin
         {ore_q, fe_q, pe_q, irq_q}     <= 4'b0000;
         {rx_s1_q, rx_s2_q, rx_prev_q}  <= 3'b111;
      end else begin
         {ore_q, fe_q, pe_q, irq_q}     <= {ore_d, fe_d, pe_d, irq_d};
         {rx_s1_q, rx_s2_q, rx_prev_q}  <= {rx, rx_s1_q, rx_s2_q};
      end
   end

   assign rx_fall_s    = rx_prev_q & ~rx_s2_q;
   assign rx_bit_end_s = tick_s & (rx_cnt_q == TICK_LAST);
   assign tx_bit_end_s = tick_s & (tx_cnt_q == TICK_LAST);

   // FSM state registers.
   always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
      if (!mcu_rst_n) begin
         rx_state_q <= RX_IDLE; rx_cnt_q <= 4'd0; rx_bit_q <= 3'd0;
         rx_shift_q <= 8'h00;   rx_par_q <= 1'b0;
         tx_state_q <= TX_IDLE; tx_cnt_q <= 4'd0; tx_bit_q <= 3'd0;
         tx_data_q  <= 8'h00;   tx_q     <= 1'b1;
      end else begin
         rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d;
         rx_shift_q <= rx_shift_d; rx_par_q <= rx_par_d;
         tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
         tx_data_q  <= tx_data_d;  tx_q     <= tx_d;
      end
   end

   // Receiver next state: start verified at mid-bit, later bits sampled every 16 ticks.
   always_comb begin
      rx_state_d = rx_state_q; rx_cnt_d = rx_cnt_q; rx_bit_d = rx_bit_q;
      rx_shift_d = rx_shift_q; rx_par_d = rx_par_q;
      rx_push_s  = 1'b0; fe_set_s = 1'b0; pe_set_s = 1'b0;
      if (!ctrl_q[CTRL_RE] || re_clr_s) begin
         rx_state_d = RX_IDLE;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               rx_cnt_d   = 4'd0;
               rx_bit_d   = 3'd0;
               rx_state_d = rx_fall_s ? RX_START : RX_IDLE;
            end
            RX_START: begin
               if (tick_s && (rx_cnt_q == TICK_MID)) begin
                  rx_cnt_d   = 4'd0;
                  rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q + {3'd0, tick_s};
               end
            end
            RX_DATA: begin
               rx_cnt_d = rx_cnt_q + {3'd0, tick_s};
               if (rx_bit_end_s) begin
                  rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                  rx_bit_d   = rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_d = ctrl_q[CTRL_PEN] ? RX_PAR : RX_STOP;
                  else                  rx_state_d = RX_DATA;
               end else begin
                  rx_state_d = RX_DATA;
               end
            end
            RX_PAR: begin
               rx_cnt_d = rx_cnt_q + {3'd0, tick_s};
               if (rx_bit_end_s) begin
                  rx_par_d   = rx_s2_q;
                  rx_state_d = RX_STOP;
               end else begin
                  rx_state_d = RX_PAR;
               end
            end
            RX_STOP: begin
               rx_cnt_d = rx_cnt_q + {3'd0, tick_s};
               if (rx_bit_end_s) begin
                  rx_push_s  = 1'b1;
                  fe_set_s   = ~rx_s2_q;
                  pe_set_s   = ctrl_q[CTRL_PEN] &
                               (rx_par_q != parity_bit(rx_shift_q, ctrl_q[CTRL_PODD]));
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_STOP;
               end
            end
            default: rx_state_d = RX_IDLE;
         endcase
      end
   end

   // Transmitter next state: each frame stage lasts 16 ticks, frames chain while data waits.
   always_comb begin
      tx_state_d = tx_state_q; tx_cnt_d = tx_cnt_q; tx_bit_d = tx_bit_q;
      tx_data_d  = tx_data_q;  tx_d     = tx_q;     tx_pop_s = 1'b0;
      if (te_clr_s) begin
         tx_state_d = TX_IDLE;
         tx_d       = 1'b1;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               tx_cnt_d = 4'd0;
               tx_bit_d = 3'd0;
               tx_d     = 1'b1;
               if (tick_s && ctrl_q[CTRL_TE] && !txf_empty_s) begin
                  tx_state_d = TX_START; tx_pop_s = 1'b1;
                  tx_data_d  = txf_rdata_s; tx_d = 1'b0;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
            TX_START: begin
               tx_cnt_d = tx_cnt_q + {3'd0, tick_s};
               if (tx_bit_end_s) begin
                  tx_state_d = TX_DATA; tx_bit_d = 3'd0; tx_d = tx_data_q[0];
               end else begin
                  tx_state_d = TX_START;
               end
            end
            TX_DATA: begin
               tx_cnt_d = tx_cnt_q + {3'd0, tick_s};
               if (tx_bit_end_s && (tx_bit_q == 3'd7)) begin
                  if (ctrl_q[CTRL_PEN]) begin
                     tx_state_d = TX_PAR;
                     tx_d       = parity_bit(tx_data_q, ctrl_q[CTRL_PODD]);
                  end else begin
                     tx_state_d = TX_STOP;
                     tx_d       = 1'b1;
                  end
               end else if (tx_bit_end_s) begin
                  tx_bit_d = tx_bit_q + 3'd1;
                  tx_d     = tx_data_q[tx_bit_q + 3'd1];
               end else begin
                  tx_state_d = TX_DATA;
               end
            end
            TX_PAR: begin
               tx_cnt_d = tx_cnt_q + {3'd0, tick_s};
               if (tx_bit_end_s) begin
                  tx_state_d = TX_STOP; tx_d = 1'b1;
               end else begin
                  tx_state_d = TX_PAR;
               end
            end
            TX_STOP: begin
               tx_cnt_d = tx_cnt_q + {3'd0, tick_s};
               if (tx_bit_end_s && ctrl_q[CTRL_TE] && !txf_empty_s) begin
                  tx_state_d = TX_START; tx_pop_s = 1'b1;
                  tx_data_d  = txf_rdata_s; tx_d = 1'b0;
               end else if (tx_bit_end_s) begin
                  tx_state_d = TX_IDLE; tx_d = 1'b1;
               end else begin
                  tx_state_d = TX_STOP;
               end
            end
            default: begin
               tx_state_d = TX_IDLE; tx_d = 1'b1;
            end
         endcase
      end
   end

   hd63701_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(mcu_clx2), .rst_n(mcu_rst_n), .flush(1'b0),
      .push(rx_push_s), .wdata(rx_shift_q), .pop(rd_data_s),
      .rdata(rxf_rdata_s), .full(rxf_full_s), .empty(rxf_empty_s), .count(rxf_count_s)
   );

   hd63701_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(mcu_clx2), .rst_n(mcu_rst_n), .flush(te_clr_s),
      .push(wr_data_s), .wdata(mcu_do), .pop(tx_pop_s),
      .rdata(txf_rdata_s), .full(txf_full_s), .empty(txf_empty_s), .count(txf_count_s)
   );

   assign tx  = tx_q;
   assign te  = ctrl_q[CTRL_TE];
   assign irq = irq_q;

endmodule
